// File: rtl/mux_nto1_seq.sv
// Registered N:1 channel mux with one-hot select decode, valid/ready output
// and either manual select loading or round-robin scan over an enable mask.
module mux_nto1_seq #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel_in,
  input  logic            sel_load,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_en,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic [N-1:0]    dec_oh
);

  localparam logic [SW:0] NL = (SW+1)'(N);

  logic [SW-1:0]         sel_q;
  logic [SW-1:0]         sel_nxt;
  logic [N-1:0][W-1:0]   ch_data;
  logic                  load;
  logic                  sel_ok;
  logic                  found;
  logic [SW:0]           cand;

  assign ch_data = in_data;
  assign load    = !out_valid || out_ready;
  // Out-of-range indices (non-power-of-two N) are dropped so sel_q stays < N.
  assign sel_ok  = sel_load && ({1'b0, sel_in} < NL);

  for (genvar k = 0; k < N; k++) begin : g_dec
    assign dec_oh[k] = (sel_q == SW'(k));
  end

  // Next enabled channel after sel_q, cyclic, with sel_q itself checked last.
  always_comb begin
    sel_nxt = sel_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, sel_q} + (SW+1)'(k);
      if (cand >= NL) cand = cand - NL;
      if (!found && in_en[cand[SW-1:0]]) begin
        sel_nxt = cand[SW-1:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (load) begin
        out_data  <= ch_data[sel_q];
        out_ch    <= sel_q;
        out_valid <= in_en[sel_q];
      end
      if (sel_ok)            sel_q <= sel_in;
      else if (mode && load) sel_q <= sel_nxt;
    end
  end

endmodule

// File: doc/mux_nto1_seq.md
# mux_nto1_seq

Parametrised, registered N:1 channel multiplexer with a one-hot decoded select, a valid/ready output handshake, and two selection modes. In manual mode the select is loaded explicitly. In scan mode the block round-robins over a per-channel enable mask. It is the sequential successor to the combinational decoder/tristate 4:1 mux. It sits between a bank of N equal-width sources and a single downstream consumer that may apply backpressure.

## Interface
Parameters:
- N, 4: channel count, ≥2, not required to be a power of two.
- W, 8: data width per channel.
- SW, $clog2(N): select width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mode  in  1  0 = manual select, 1 = round-robin scan.
- sel_in  in  SW  channel index to load.
- sel_load  in  1  load sel_in into the select register this cycle.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_en  in  N  per-channel enable/valid mask.
- out_ready  in  1  consumer accepts the output beat.
- out_valid  out  1  output beat valid.
- out_data  out  W  registered data of the captured channel.
- out_ch  out  SW  index of the captured channel.
- dec_oh  out  N  one-hot decode of the current select register.

## Operation
- State: select register sel_q [SW-1:0], plus output registers out_valid, out_data and out_ch.
- dec_oh is combinational from sel_q: bit sel_q = 1, all other bits 0.
- load = !out_valid || out_ready. This is the capture enable.
- On load:
  - out_data ← in_data[sel_q*W +: W].
  - out_ch ← sel_q.
  - out_valid ← in_en[sel_q].
- Without load, the output registers hold. out_data and out_ch must stay stable while out_valid=1 and out_ready=0.
- Select update, in priority order:
  1. sel_load=1 and sel_in < N: sel_q ← sel_in, in either mode. If sel_in ≥ N, sel_load is ignored and the lower priorities apply.
  2. mode=1 and load: sel_q ← the first index j with in_en[j]=1, searching sel_q+1, sel_q+2, … cyclically modulo N, with sel_q itself checked last. If in_en is all zero, sel_q holds.
  3. Otherwise sel_q holds.
- Manual mode never auto-advances. A disabled selected channel produces out_valid=0 after load.
- sel_load coinciding with load: the capture uses the old sel_q, and the new select applies from the next cycle.
- Changing mode takes effect for the next load. In-flight output registers are unaffected.
- Wrap-around: advancing from N-1 goes to index 0. For non-power-of-two N, index values ≥ N are never reached.

## Timing
- Reset (async assert, any cycle, including mid-transfer) sets:
  - sel_q = 0, dec_oh = 1;
  - out_valid = 0, out_data = 0, out_ch = 0.
- Deassertion is synchronous to clk via the normal flop release. The first load occurs on the first rising edge after deassertion.
- Latency: in_data/in_en sampled at edge t appear on out_data/out_valid after edge t (1 cycle).
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, all outputs and sel_q (except through sel_load) are frozen. A stalled beat is never dropped or replaced.
- dec_oh tracks sel_q with zero added latency.
- Scan with all channels enabled and out_ready held at 1: out_ch sequence is 0,1,…,N-1,0,… on consecutive cycles.

## Test plan
- Reset mid-transfer: out_valid=1, out_ready=0 → assert rst_n=0 → out_valid=0, out_data=0, out_ch=0, dec_oh=4'b0001 immediately, without waiting for clk.
- Manual, N=4, W=8: in_data={8'hD3,8'hC2,8'hB1,8'hA0}, in_en=4'hF, sel_in=2, sel_load pulse, out_ready=1 → dec_oh=4'b0100 next cycle; out_data=8'hC2, out_ch=2 one cycle later.
- Scan with skip: mode=1, in_en=4'b1010, out_ready=1 → out_ch sequence 1,3,1,3…; values 0 and 2 never appear with out_valid=1.
- Backpressure: scan, in_en=4'hF, out_ready=0 for 3 cycles while out_valid=1 at ch 1 → out_data/out_ch unchanged; after release, next out_ch=2.
- Empty mask: mode=1, in_en=0 → out_valid=0 after one load and sel_q constant; set in_en=4'b1000 → out_valid=1 with out_ch=3.
- Boundaries: N=5; sel_in=7 with sel_load → sel_q unchanged. Scan from ch 4 → wraps to ch 0. sel_load=1 with load in scan → captured out_ch is the old sel_q, and sel_q becomes sel_in.
